pac_rr_src_frontend: RTL and testbench
======================================

// Module: pac_rr_src_frontend
// PURPOSE
//  Requester-side front end for the weighted round-robin arbiter core. Buffers
//  per-client write traffic in N small FIFOs and raises req_o[k] while FIFO k
//  holds data. It follows the arbiter's grant_o/grant_idx_o, drives
//  src_valid_i and the data to the sink, and pops the granted FIFO on each
//  accepted beat. It sits between the N client ports and the arbiter/sink pair.
// PARAMETERS
//  N          4  number of clients/FIFOs (matches arbiter N)
//  IDX_WIDTH  2  log2(N), width of grant index
//  DW         8  data word width
//  DEPTH      4  entries per FIFO (power of 2, >=2)
//  PTR_W      2  log2(DEPTH)
// PORTS
//  clk_i        in   1          clock
//  rst_ni       in   1          reset, asynchronous, active-low
//  wr_valid_i   in   N          client k presents a word
//  wr_data_i    in   N*DW       client k data at bits [k*DW +: DW]
//  wr_ready_o   out  N          FIFO k not full
//  req_o        out  N          to arbiter req_i; FIFO k non-empty
//  grant_i      in   N          from arbiter grant_o (one-hot or zero)
//  grant_idx_i  in   IDX_WIDTH  from arbiter grant_idx_o
//  src_valid_o  out  1          to arbiter src_valid_i and to sink
//  sink_ready_i in   1          sink accepts a beat (shared with arbiter)
//  out_data_o   out  DW         head word of FIFO grant_idx_i
//  out_src_o    out  IDX_WIDTH  source index of the current beat (= grant_idx_i)
//  level_o      out  N*(PTR_W+1) per-FIFO occupancy 0..DEPTH
//  err_o        out  1          sticky protocol error
//  clr_err_i    in   1          clears err_o
// BEHAVIOUR
//  Reset (async): all FIFO pointers/counts=0, err_o=0.
//   Hence wr_ready_o=all 1s, req_o=0, src_valid_o=0, level_o=0.
//  FIFO k push: wr_valid_i[k] & wr_ready_o[k].
//   wr_ready_o[k] = (count_k != DEPTH) and does not depend on same-cycle pop.
//   A full FIFO therefore refuses a push even when popping that cycle.
//  req_o[k] = (count_k != 0), decoded from registers with no bypass.
//   Push into an empty FIFO at edge t gives req_o[k]=1 from cycle t+1.
//  src_valid_o = (|grant_i) & grant_i[grant_idx_i] & req_o[grant_idx_i].
//  out_data_o = mem[grant_idx_i][rd_ptr]; out_src_o = grant_idx_i.
//   Both are valid only while src_valid_o=1; values otherwise are don't-care.
//  Pop: beat = src_valid_o & sink_ready_i. On a beat, FIFO grant_idx_i pops.
//   rd_ptr and count update at the next edge.
//   The arbiter then rotates, so at most one beat per grant.
//  Simultaneous push and pop on the same FIFO: count unchanged.
//   Both pointers advance and wrap modulo DEPTH.
//  Last entry popped: req_o[k] drops the following cycle.
//   The arbiter sees the request vanish and returns to PICK/IDLE.
//  Pushes to non-granted FIFOs proceed independently every cycle.
//  err_o sets at the next edge on any of:
//   (a) grant_i not one-hot and non-zero;
//   (b) grant_i != 0 and grant_i != (1<<grant_idx_i);
//   (c) grant_i[k]=1 while count_k==0.
//   err_o clears only via clr_err_i. If set and clear occur in the same cycle,
//   set wins.
//  No FSM beyond the FIFOs. Reset mid-transfer discards all buffered data.
//   No beat completes in the reset cycle.
// TESTING
//  1 Reset; push 0xA1 to client 2 -> wr_ready_o=4'hF; req_o=4'b0100 one cycle
//    later; level_o[2]=1.
//  2 Client 2 holds 0xA1,0xA2; drive grant_i=4'b0100, grant_idx_i=2,
//    sink_ready_i=1 -> src_valid_o=1, out_data_o=0xA1, out_src_o=2;
//    next grant yields 0xA2; then req_o[2]=0.
//  3 Fill client 0 with 4 words -> wr_ready_o[0]=0; a 5th push with a
//    simultaneous pop is refused; level_o[0] goes 4->3; pointers wrap correctly
//    after 6 push/pop pairs.
//  4 Grant client 1 with sink_ready_i=0 for 3 cycles -> src_valid_o=1 held,
//    out_data_o stable, level unchanged; release ready -> exactly one pop.
//  5 Drive grant_i=4'b0011, then grant_i=4'b1000 with FIFO 3 empty ->
//    err_o=1 after one edge; clr_err_i with no new error -> err_o=0;
//    clr_err_i concurrent with a new error -> err_o stays 1.
//  6 Assert rst_ni low with 3 FIFOs partly full mid-grant -> all outputs
//    immediately at reset values; no pop recorded.

Source files
------------

// File: rtl/pac_rr_src_frontend.sv
// -----------------------------------------------------------------------------
// pac_rr_src_frontend
//   Requester-side front end for the weighted round-robin arbiter core.
//   Each of N clients writes into its own small FIFO. req_o[k] is raised while
//   FIFO k holds data. When the arbiter grants a client, the head word of that
//   client's FIFO is presented to the sink. The FIFO pops on every accepted beat
//   (src_valid_o & sink_ready_i).
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_valid_i      per-client write strobe
//   wr_data_i       per-client write data, client k at [k*DW +: DW]
//   wr_ready_o      FIFO k not full; independent of a same-cycle pop
//   req_o           FIFO k non-empty, sent to the arbiter req_i
//   grant_i         arbiter grant vector (one-hot or zero)
//   grant_idx_i     arbiter grant index
//   src_valid_o     granted FIFO has a head word, sent to arbiter and sink
//   sink_ready_i    sink accepts the current beat
//   out_data_o      head word of FIFO grant_idx_i
//   out_src_o       source index of the current beat
//   level_o         per-FIFO occupancy, FIFO k at [k*(PTR_W+1) +: PTR_W+1]
//   err_o           sticky protocol error (bad grant or grant to empty FIFO)
//   clr_err_i       clears err_o; a new error in the same cycle wins
// -----------------------------------------------------------------------------
module pac_rr_src_frontend #(
  parameter int N         = 4,
  parameter int IDX_WIDTH = 2,
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N-1:0]           wr_valid_i,
  input  logic [N*DW-1:0]        wr_data_i,
  output logic [N-1:0]           wr_ready_o,
  output logic [N-1:0]           req_o,
  input  logic [N-1:0]           grant_i,
  input  logic [IDX_WIDTH-1:0]   grant_idx_i,
  output logic                   src_valid_o,
  input  logic                   sink_ready_i,
  output logic [DW-1:0]          out_data_o,
  output logic [IDX_WIDTH-1:0]   out_src_o,
  output logic [N*(PTR_W+1)-1:0] level_o,
  output logic                   err_o,
  input  logic                   clr_err_i
);

  localparam int CW = PTR_W + 1;

  logic [DW-1:0]    mem_q    [N][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [N];
  logic [PTR_W-1:0] rd_ptr_q [N];
  logic [CW-1:0]    count_q  [N];

  logic [N-1:0] full;
  logic [N-1:0] nonempty;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic [N-1:0] idx_onehot;
  logic         beat;
  logic         err_set;

  always_comb begin
    full     = '0;
    nonempty = '0;
    level_o  = '0;
    for (int k = 0; k < N; k++) begin
      full[k]                = (count_q[k] == CW'(DEPTH));
      nonempty[k]            = (count_q[k] != '0);
      level_o[k*CW +: CW]    = count_q[k];
    end
  end

  assign wr_ready_o  = ~full;
  assign req_o       = nonempty;

  // A beat needs a grant that actually points at a FIFO holding data.
  assign src_valid_o = (|grant_i) & grant_i[grant_idx_i] & nonempty[grant_idx_i];
  assign beat        = src_valid_o & sink_ready_i;
  assign out_data_o  = mem_q[grant_idx_i][rd_ptr_q[grant_idx_i]];
  assign out_src_o   = grant_idx_i;

  // Full is taken from the registered count, so a full FIFO refuses a push
  // even in a cycle where it is being popped.
  assign push = wr_valid_i & ~full;

  always_comb begin
    pop        = '0;
    idx_onehot = '0;
    idx_onehot[grant_idx_i] = 1'b1;
    for (int k = 0; k < N; k++) begin
      pop[k] = beat & (grant_idx_i == IDX_WIDTH'(k));
    end
  end

  // Error sources: multiple grant bits, grant bit disagreeing with the index,
  // or a grant to a FIFO that holds nothing.
  assign err_set = (|(grant_i & (grant_i - {{(N-1){1'b0}}, 1'b1})))
                 | ((grant_i != '0) & (grant_i != idx_onehot))
                 | (|(grant_i & ~nonempty));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
        case ({push[k], pop[k]})
          2'b10:   count_q[k] <= count_q[k] + CW'(1);
          2'b01:   count_q[k] <= count_q[k] - CW'(1);
          default: count_q[k] <= count_q[k];
        endcase
      end
    end
  end

  // Storage carries no reset: contents are meaningless while count is zero.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= wr_data_i[k*DW +: DW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        err_o <= 1'b0;
    else if (err_set)   err_o <= 1'b1;
    else if (clr_err_i) err_o <= 1'b0;
  end

endmodule

// File: tb/tb_pac_rr_src_frontend.sv
module tb_pac_rr_src_frontend;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  wr_valid_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_ready_o;
  logic [3:0]  req_o;
  logic [3:0]  grant_i;
  logic [1:0]  grant_idx_i;
  logic        src_valid_o;
  logic        sink_ready_i;
  logic [7:0]  out_data_o;
  logic [1:0]  out_src_o;
  logic [11:0] level_o;
  logic        err_o;
  logic        clr_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  pac_rr_src_frontend dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .req_o        (req_o),
    .grant_i      (grant_i),
    .grant_idx_i  (grant_idx_i),
    .src_valid_o  (src_valid_o),
    .sink_ready_i (sink_ready_i),
    .out_data_o   (out_data_o),
    .out_src_o    (out_src_o),
    .level_o      (level_o),
    .err_o        (err_o),
    .clr_err_i    (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [2:0] lvl(input int k);
    return level_o[k*3 +: 3];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid_i   = '0;
    wr_data_i    = '0;
    grant_i      = '0;
    grant_idx_i  = '0;
    sink_ready_i = 1'b0;
    clr_err_i    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    n_checks++; if (wr_ready_o !== 4'hF) begin n_fail++; $display("FAIL reset_wr_ready: got %h expected %h", wr_ready_o, 4'hF); end
    n_checks++; if (req_o !== 4'h0) begin n_fail++; $display("FAIL reset_req: got %h expected %h", req_o, 4'h0); end
    n_checks++; if (src_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_src_valid: got %b expected 0", src_valid_o); end
    n_checks++; if (level_o !== 12'h000) begin n_fail++; $display("FAIL reset_level: got %h expected 000", level_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single_push();
    wr_valid_i = 4'b0100;
    wr_data_i  = 32'h00A1_0000;
    #1;
    n_checks++; if (wr_ready_o !== 4'hF) begin n_fail++; $display("FAIL push_wr_ready: got %h expected F", wr_ready_o); end
    n_checks++; if (req_o !== 4'h0) begin n_fail++; $display("FAIL push_req_no_bypass: got %h expected 0", req_o); end
    step();
    wr_valid_i = '0;
    #1;
    n_checks++; if (req_o !== 4'b0100) begin n_fail++; $display("FAIL push_req: got %b expected 0100", req_o); end
    n_checks++; if (lvl(2) !== 3'd1) begin n_fail++; $display("FAIL push_level2: got %0d expected 1", lvl(2)); end
  endtask

  task automatic test_grant_two();
    wr_valid_i = 4'b0100;
    wr_data_i  = 32'h00A2_0000;
    step();
    wr_valid_i = '0;
    n_checks++; if (lvl(2) !== 3'd2) begin n_fail++; $display("FAIL grant_level_pre: got %0d expected 2", lvl(2)); end
    grant_i      = 4'b0100;
    grant_idx_i  = 2'd2;
    sink_ready_i = 1'b1;
    #1;
    n_checks++; if (src_valid_o !== 1'b1) begin n_fail++; $display("FAIL grant_valid1: got %b expected 1", src_valid_o); end
    n_checks++; if (out_data_o !== 8'hA1) begin n_fail++; $display("FAIL grant_data1: got %h expected A1", out_data_o); end
    n_checks++; if (out_src_o !== 2'd2) begin n_fail++; $display("FAIL grant_src1: got %0d expected 2", out_src_o); end
    step();
    n_checks++; if (out_data_o !== 8'hA2) begin n_fail++; $display("FAIL grant_data2: got %h expected A2", out_data_o); end
    n_checks++; if (lvl(2) !== 3'd1) begin n_fail++; $display("FAIL grant_level_mid: got %0d expected 1", lvl(2)); end
    step();
    n_checks++; if (req_o !== 4'b0000) begin n_fail++; $display("FAIL grant_req_drop: got %b expected 0000", req_o); end
    n_checks++; if (src_valid_o !== 1'b0) begin n_fail++; $display("FAIL grant_valid_drop: got %b expected 0", src_valid_o); end
    idle_inputs();
    step();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL grant_no_err: got %b expected 0", err_o); end
  endtask

  task automatic test_full_wrap();
    logic [7:0] exp_q[$];
    for (int i = 0; i < 4; i++) begin
      wr_valid_i = 4'b0001;
      wr_data_i  = {24'h0, 8'h10 + 8'(i)};
      step();
    end
    wr_valid_i = '0;
    n_checks++; if (wr_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", wr_ready_o[0]); end
    n_checks++; if (lvl(0) !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d expected 4", lvl(0)); end
    // push of 0x14 while popping a full FIFO must be refused
    wr_valid_i   = 4'b0001;
    wr_data_i    = 32'h0000_0014;
    grant_i      = 4'b0001;
    grant_idx_i  = 2'd0;
    sink_ready_i = 1'b1;
    #1;
    n_checks++; if (wr_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready_pop: got %b expected 0", wr_ready_o[0]); end
    n_checks++; if (out_data_o !== 8'h10) begin n_fail++; $display("FAIL full_head: got %h expected 10", out_data_o); end
    step();
    n_checks++; if (lvl(0) !== 3'd3) begin n_fail++; $display("FAIL full_level_after: got %0d expected 3", lvl(0)); end
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    for (int i = 0; i < 6; i++) begin
      wr_data_i = {24'h0, 8'h20 + 8'(i)};
      #1;
      n_checks++; if (out_data_o !== exp_q[i]) begin n_fail++; $display("FAIL wrap_data%0d: got %h expected %h", i, out_data_o, exp_q[i]); end
      step();
    end
    wr_valid_i = '0;
    n_checks++; if (lvl(0) !== 3'd3) begin n_fail++; $display("FAIL wrap_level: got %0d expected 3", lvl(0)); end
    for (int i = 6; i < 9; i++) begin
      #1;
      n_checks++; if (out_data_o !== exp_q[i]) begin n_fail++; $display("FAIL drain_data%0d: got %h expected %h", i, out_data_o, exp_q[i]); end
      step();
    end
    n_checks++; if (lvl(0) !== 3'd0) begin n_fail++; $display("FAIL drain_level: got %0d expected 0", lvl(0)); end
    idle_inputs();
    step();
  endtask

  task automatic test_stall();
    wr_valid_i = 4'b0010;
    wr_data_i  = 32'h0000_3000;
    step();
    wr_data_i  = 32'h0000_3100;
    step();
    wr_valid_i   = '0;
    grant_i      = 4'b0010;
    grant_idx_i  = 2'd1;
    sink_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (src_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d: got %b expected 1", i, src_valid_o); end
      n_checks++; if (out_data_o !== 8'h30) begin n_fail++; $display("FAIL stall_data%0d: got %h expected 30", i, out_data_o); end
      n_checks++; if (lvl(1) !== 3'd2) begin n_fail++; $display("FAIL stall_level%0d: got %0d expected 2", i, lvl(1)); end
      step();
    end
    sink_ready_i = 1'b1;
    step();
    grant_i      = '0;
    sink_ready_i = 1'b0;
    n_checks++; if (lvl(1) !== 3'd1) begin n_fail++; $display("FAIL stall_pop: got %0d expected 1", lvl(1)); end
    step();
    n_checks++; if (lvl(1) !== 3'd1) begin n_fail++; $display("FAIL stall_one_pop: got %0d expected 1", lvl(1)); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL stall_no_err: got %b expected 0", err_o); end
  endtask

  task automatic test_err();
    // FIFO 1 holds one word, others empty
    grant_i     = 4'b0011;
    grant_idx_i = 2'd0;
    #1;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_before_edge: got %b expected 0", err_o); end
    step();
    grant_i = '0;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_multi_grant: got %b expected 1", err_o); end
    step();
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_o); end
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err_o); end
    grant_i     = 4'b1000;
    grant_idx_i = 2'd3;
    #1;
    n_checks++; if (src_valid_o !== 1'b0) begin n_fail++; $display("FAIL err_empty_valid: got %b expected 0", src_valid_o); end
    step();
    grant_i = '0;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_empty_grant: got %b expected 1", err_o); end
    clr_err_i = 1'b1;
    step();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear2: got %b expected 0", err_o); end
    // clear together with a new error: set wins
    grant_i     = 4'b1000;
    grant_idx_i = 2'd3;
    step();
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b expected 1", err_o); end
    grant_i = '0;
    step();
    clr_err_i = 1'b0;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear3: got %b expected 0", err_o); end
    // one-hot grant whose index disagrees; granted FIFO 1 is non-empty
    grant_i     = 4'b0010;
    grant_idx_i = 2'd0;
    step();
    grant_i = '0;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_idx_mismatch: got %b expected 1", err_o); end
    n_checks++; if (lvl(1) !== 3'd1) begin n_fail++; $display("FAIL err_no_pop: got %0d expected 1", lvl(1)); end
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_valid_i = 4'b1101;
    wr_data_i  = 32'h4400_4240;
    step();
    wr_valid_i = '0;
    n_checks++; if (req_o !== 4'b1111) begin n_fail++; $display("FAIL rmid_req: got %b expected 1111", req_o); end
    grant_i      = 4'b0100;
    grant_idx_i  = 2'd2;
    sink_ready_i = 1'b1;
    #1;
    n_checks++; if (src_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_valid: got %b expected 1", src_valid_o); end
    rst_ni = 1'b0;
    #1;
    n_checks++; if (wr_ready_o !== 4'hF) begin n_fail++; $display("FAIL rmid_wr_ready: got %h expected F", wr_ready_o); end
    n_checks++; if (req_o !== 4'h0) begin n_fail++; $display("FAIL rmid_req_clr: got %b expected 0000", req_o); end
    n_checks++; if (src_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_clr: got %b expected 0", src_valid_o); end
    n_checks++; if (level_o !== 12'h000) begin n_fail++; $display("FAIL rmid_level: got %h expected 000", level_o); end
    step();
    idle_inputs();
    rst_ni = 1'b1;
    step();
    n_checks++; if (level_o !== 12'h000) begin n_fail++; $display("FAIL rmid_level_after: got %h expected 000", level_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b expected 0", err_o); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_grant_two();
    test_full_wrap();
    test_stall();
    test_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
